// File: rtl/lc3b_mem_responder_pkg.sv
// Shared types for the LC-3b memory responder and its word array.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    mem_idle    = 2'd0,
    mem_busy    = 2'd1,
    mem_resp_st = 2'd2
  } lc3b_memstate;

endpackage

// File: rtl/lc3b_mem_responder_array.sv
// Synchronous single-port word array: byte write enables, registered read.
// The read register can be forced to zero (used for rejected accesses) and
// holds its value when no read is issued. Array contents are never reset.
module lc3b_mem_array
  import lc3b_types::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  lc3b_mem_wmask be,
  input  logic          re,
  input  logic          rd_zero,
  input  logic [AW-1:0] idx,
  input  lc3b_word      wdata,
  output lc3b_word      rdata
);

  lc3b_word mem [DEPTH_WORDS];
  lc3b_word rdata_q, rdata_d;

  // Byte-granular write port.
  always_ff @(posedge clk) begin
    if (we && be[0]) mem[idx][7:0]  <= wdata[7:0];
    if (we && be[1]) mem[idx][15:8] <= wdata[15:8];
  end

  // Read register only changes when a read is issued.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = rd_zero ? 16'h0000 : mem[idx];
  end

  // Read data register, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) rdata_q <= 16'h0000;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lc3b_mem_responder.sv
// LC-3b memory-side responder: fixed-latency read/write handshake over an
// internal byte-writable array. Optional feature macro:
// LC3B_MEM_BOUNDS_CHECK_EN -- out-of-range word index suppresses the write,
// reads return zero and mem_error pulses with mem_resp. Without it the index
// wraps modulo DEPTH_WORDS and mem_error is tied low.
module lc3b_mem_responder
  import lc3b_types::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_mem_wmask mem_byte_enable,
  input  logic [15:0]   mem_address,
  input  lc3b_word      mem_wdata,
  output lc3b_word      mem_rdata,
  output logic          mem_resp,
  output logic          mem_error
);

  localparam int         AW   = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LOAD = 4'(LATENCY - 1);

  lc3b_memstate  state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [14:0]   idx_q, idx_d;
  lc3b_mem_wmask be_q, be_d;
  lc3b_word      wd_q, wd_d;
  logic          resp_q, resp_d;
  logic          err_q, err_d;

  logic          req;
  logic          acc_wr;
  logic [14:0]   acc_idx;
  lc3b_mem_wmask acc_be;
  lc3b_word      acc_wd;
  logic          oob;
  logic          arr_we, arr_re;
  logic          unused_bits;

  assign req = mem_read | mem_write;

  // Access fields: latched copy while BUSY; live inputs when LATENCY==1
  // completes the access on the same edge that accepts it.
  always_comb begin
    acc_wr  = wr_q;
    acc_idx = idx_q;
    acc_be  = be_q;
    acc_wd  = wd_q;
    if (state_q != mem_busy) begin
      acc_wr  = mem_write;
      acc_idx = mem_address[15:1];
      acc_be  = mem_byte_enable;
      acc_wd  = mem_wdata;
    end
  end

`ifdef LC3B_MEM_BOUNDS_CHECK_EN
  assign oob = 32'(acc_idx) >= 32'(DEPTH_WORDS);
`else
  assign oob = 1'b0;
`endif

  // FSM, latency counter and request latch. RESP accepts a new request like
  // IDLE so back-to-back accesses lose no cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    be_d    = be_q;
    wd_d    = wd_q;
    resp_d  = 1'b0;
    err_d   = 1'b0;
    arr_we  = 1'b0;
    arr_re  = 1'b0;
    case (state_q)
      mem_busy: begin
        if (!req) begin
          state_d = mem_idle;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d = mem_resp_st;
          cnt_d   = 4'd0;
          resp_d  = 1'b1;
          err_d   = oob;
          arr_we  = acc_wr & ~oob;
          arr_re  = ~acc_wr;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = mem_idle;
        if (req) begin
          wr_d  = mem_write;
          idx_d = mem_address[15:1];
          be_d  = mem_byte_enable;
          wd_d  = mem_wdata;
          if (LATENCY == 1) begin
            state_d = mem_resp_st;
            cnt_d   = 4'd0;
            resp_d  = 1'b1;
            err_d   = oob;
            arr_we  = acc_wr & ~oob;
            arr_re  = ~acc_wr;
          end else begin
            state_d = mem_busy;
            cnt_d   = LOAD;
          end
        end
      end
    endcase
    // Reset discards whatever access would have completed this edge.
    if (reset) begin
      arr_we = 1'b0;
      arr_re = 1'b0;
    end
  end

  // Control and latch registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= mem_idle;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= 15'd0;
      be_q    <= 2'b00;
      wd_q    <= 16'h0000;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
    end
  end

  lc3b_mem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk     (clk),
    .reset   (reset),
    .we      (arr_we),
    .be      (acc_be),
    .re      (arr_re),
    .rd_zero (oob),
    .idx     (acc_idx[AW-1:0]),
    .wdata   (acc_wd),
    .rdata   (mem_rdata)
  );

  // Byte-address bit 0 is ignored; upper index bits are dropped when wrapping.
  assign unused_bits = ^{mem_address[0], acc_idx};

  assign mem_resp = resp_q;
`ifdef LC3B_MEM_BOUNDS_CHECK_EN
  assign mem_error = err_q;
`else
  assign mem_error = 1'b0;
`endif

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Directed bench for lc3b_mem_responder: one LATENCY=4 instance and one
// LATENCY=1 instance sharing the request inputs.
module tb_lc3b_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address, mem_wdata;
  logic [15:0] rdata0, rdata1;
  logic        resp0, resp1, err0, err1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lc3b_mem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(rdata0), .mem_resp(resp0), .mem_error(err0)
  );

  lc3b_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(rdata1), .mem_resp(resp1), .mem_error(err1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one request on a negedge, hold until the selected instance
  // responds (bounded), then drop it. lat = cycles from request to mem_resp.
  task automatic access(input int which, input logic rd, input logic wr,
                        input logic [1:0] be, input logic [15:0] addr,
                        input logic [15:0] wd, output int lat,
                        output logic [15:0] rdata, output logic err);
    logic r;
    lat = -1; rdata = 16'hxxxx; err = 1'bx;
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_byte_enable = be;
    mem_address = addr; mem_wdata = wd;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      r = (which != 0) ? resp1 : resp0;
      if (r) begin
        lat   = k;
        rdata = (which != 0) ? rdata1 : rdata0;
        err   = (which != 0) ? err1 : err0;
        break;
      end
    end
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          lat, k1, k2, nresp;
    logic [15:0] rd;
    logic        er;

    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = 2'b00; mem_address = 16'h0000; mem_wdata = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp",  32'(resp0),  32'h0);
    chk("rst_err",   32'(err0),   32'h0);
    chk("rst_rdata", 32'(rdata0), 32'h0);
    reset = 1'b0;

    // Basic write then read.
    access(0, 1'b0, 1'b1, 2'b11, 16'h0010, 16'hBEEF, lat, rd, er);
    chk("wr_beef_lat", 32'(lat), 32'd4);
    chk("wr_beef_err", 32'(er),  32'h0);
    access(0, 1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, lat, rd, er);
    chk("rd_beef_lat",  32'(lat), 32'd4);
    chk("rd_beef_data", 32'(rd),  32'hBEEF);

    // Byte mask and ignored address bit 0.
    access(0, 1'b0, 1'b1, 2'b11, 16'h0020, 16'h1234, lat, rd, er);
    chk("wr_1234_lat", 32'(lat), 32'd4);
    access(0, 1'b0, 1'b1, 2'b10, 16'h0020, 16'hAB00, lat, rd, er);
    chk("wr_ab00_lat", 32'(lat), 32'd4);
    access(0, 1'b1, 1'b0, 2'b00, 16'h0021, 16'h0000, lat, rd, er);
    chk("rd_mask_lat",  32'(lat), 32'd4);
    chk("rd_mask_data", 32'(rd),  32'hAB34);

    // Mask 00 completes but leaves the word alone.
    access(0, 1'b0, 1'b1, 2'b00, 16'h0020, 16'hFFFF, lat, rd, er);
    chk("wr_m00_lat", 32'(lat), 32'd4);
    access(0, 1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, lat, rd, er);
    chk("rd_m00_data", 32'(rd), 32'hAB34);

    // Back-to-back: read held through and past the first response.
    @(negedge clk);
    mem_read = 1'b1; mem_address = 16'h0010;
    k1 = -1; k2 = -1;
    for (int k = 1; k <= 20 && k2 < 0; k++) begin
      @(negedge clk);
      if (resp0) begin
        if (k1 < 0) begin
          k1 = k;
          chk("b2b_data1", 32'(rdata0), 32'hBEEF);
        end else begin
          k2 = k;
          chk("b2b_data2", 32'(rdata0), 32'hBEEF);
        end
      end
    end
    mem_read = 1'b0;
    chk("b2b_first", 32'(k1), 32'd4);
    chk("b2b_gap",   32'(k2 - k1), 32'd4);
    @(negedge clk);

    // Read dropped in cycle t+2: no response, rdata holds.
    @(negedge clk);
    mem_read = 1'b1; mem_address = 16'h0020;
    nresp = 0;
    @(negedge clk); if (resp0) nresp++;
    @(negedge clk); if (resp0) nresp++;
    mem_read = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); if (resp0) nresp++;
    end
    chk("abort_nresp", 32'(nresp), 32'd0);
    chk("abort_rdata", 32'(rdata0), 32'hBEEF);

    // Reset mid-write in cycle t+2: write discarded, outputs cleared.
    @(negedge clk);
    mem_write = 1'b1; mem_byte_enable = 2'b11;
    mem_address = 16'h0020; mem_wdata = 16'h7777;
    nresp = 0;
    @(negedge clk); if (resp0) nresp++;
    @(negedge clk); if (resp0) nresp++;
    reset = 1'b1; mem_write = 1'b0;
    @(negedge clk);
    chk("mrst_resp",  32'(resp0),  32'h0);
    chk("mrst_err",   32'(err0),   32'h0);
    chk("mrst_rdata", 32'(rdata0), 32'h0);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); if (resp0) nresp++;
    end
    chk("mrst_nresp", 32'(nresp), 32'd0);
    access(0, 1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, lat, rd, er);
    chk("mrst_rd_lat",  32'(lat), 32'd4);
    chk("mrst_rd_data", 32'(rd),  32'hAB34);

    // Out-of-range index 0x101 (byte address 0x0202).
    access(0, 1'b0, 1'b1, 2'b11, 16'h0002, 16'h1111, lat, rd, er);
    chk("oob_pre_lat", 32'(lat), 32'd4);
    access(0, 1'b0, 1'b1, 2'b11, 16'h0202, 16'h5555, lat, rd, er);
    chk("oob_wr_lat", 32'(lat), 32'd4);
`ifdef LC3B_MEM_BOUNDS_CHECK_EN
    chk("oob_wr_err", 32'(er), 32'h1);
    access(0, 1'b1, 1'b0, 2'b00, 16'h0002, 16'h0000, lat, rd, er);
    chk("oob_word1", 32'(rd), 32'h1111);
    access(0, 1'b1, 1'b0, 2'b00, 16'h0202, 16'h0000, lat, rd, er);
    chk("oob_rd_lat",  32'(lat), 32'd4);
    chk("oob_rd_data", 32'(rd),  32'h0000);
    chk("oob_rd_err",  32'(er),  32'h1);
`else
    chk("oob_wr_err", 32'(er), 32'h0);
    access(0, 1'b1, 1'b0, 2'b00, 16'h0002, 16'h0000, lat, rd, er);
    chk("oob_word1", 32'(rd), 32'h5555);
`endif

    // LATENCY=1 instance: simultaneous read+write acts as a write.
    access(1, 1'b0, 1'b1, 2'b11, 16'h0040, 16'hC0DE, lat, rd, er);
    chk("l1_wr_lat", 32'(lat), 32'd1);
    access(1, 1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000, lat, rd, er);
    chk("l1_rd_lat",  32'(lat), 32'd1);
    chk("l1_rd_data", 32'(rd),  32'hC0DE);
    access(1, 1'b1, 1'b1, 2'b11, 16'h0040, 16'h1357, lat, rd, er);
    chk("l1_rw_lat",   32'(lat), 32'd1);
    chk("l1_rw_rdata", 32'(rd),  32'hC0DE);
    access(1, 1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000, lat, rd, er);
    chk("l1_rd2_data", 32'(rd), 32'h1357);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
